slow_mem_responder: RTL and testbench

// - Responder end of the cache<->memory line interface driven by Icache/Dcache.
// - Accepts one 128-bit line read or write, waits a programmable latency, then pulses mem_ready.
// - Backs DEPTH lines of storage; one instance per cache (I-side, D-side) in bench and FPGA builds.

---
 rtl/slow_mem_responder.sv | 142 ++++++++++++++
 tb/tb_slow_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/slow_mem_responder.sv
// Line-granular memory responder with a fixed programmable latency.
// Define MEM_STATS_EN to add saturating read/write completion counters.
module slow_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
`ifdef MEM_STATS_EN
  output logic         mem_err,
  output logic [15:0]  stat_rd,
  output logic [15:0]  stat_wr
`else
  output logic         mem_err
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    TURN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]            cnt_q;
  logic                  op_wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [127:0]          wdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  commit;

  logic [127:0] mem [DEPTH];

  // mem_addr already drops the byte offset, so the line index is its low bits
  logic unused_addr;
  assign unused_addr = ^mem_addr[27:DEPTH_LOG2];

  assign accept = (state_q == IDLE) && (mem_read || mem_write);
  assign commit = (state_q == DONE) && !proc_reset;
  assign mem_err = err_q;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_ready = 1'b0;
    mem_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        mem_ready = 1'b1;
        if (!op_wr_q) begin
          mem_rdata = mem[idx_q];
        end
        state_d = TURN;
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        // simultaneous read+write resolves to a write and flags the cache
        op_wr_q <= mem_write;
        idx_q   <= mem_addr[DEPTH_LOG2-1:0];
        wdata_q <= mem_wdata;
        cnt_q   <= 8'(LATENCY - 1);
        if (mem_read && mem_write) begin
          err_q <= 1'b1;
        end
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // storage is deliberately not reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (commit && op_wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      stat_rd <= '0;
      stat_wr <= '0;
    end else if (commit) begin
      if (op_wr_q) begin
        if (stat_wr != 16'hFFFF) begin
          stat_wr <= stat_wr + 16'd1;
        end
      end else begin
        if (stat_rd != 16'hFFFF) begin
          stat_rd <= stat_rd + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_slow_mem_responder.sv
// Randomized bench for slow_mem_responder against a line-array reference model.
module tb_slow_mem_responder;

  localparam int LAT = 4;
  localparam int DL  = 8;
  localparam int N   = 1 << DL;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         mem_err;
`ifdef MEM_STATS_EN
  logic [15:0]  stat_rd;
  logic [15:0]  stat_wr;
`endif

  int total = 0;
  int bad   = 0;

  logic [127:0] model [N];
  bit           err_m;
  int           rd_m;
  int           wr_m;

  always #5 clk = ~clk;

  slow_mem_responder #(
    .LATENCY(LAT),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk(clk),
    .proc_reset(proc_reset),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
`ifdef MEM_STATS_EN
    .mem_err(mem_err),
    .stat_rd(stat_rd),
    .stat_wr(stat_wr)
`else
    .mem_err(mem_err)
`endif
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic check_stats();
`ifdef MEM_STATS_EN
    check("stat_rd", 128'(stat_rd), 128'(rd_m));
    check("stat_wr", 128'(stat_wr), 128'(wr_m));
`endif
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_ready && k < LAT + 10);
  endtask

  // Called at a negedge with the responder idle; returns at an idle negedge.
  task automatic txn(input logic rd, input logic wr,
                     input logic [27:0] a, input logic [127:0] d,
                     input bit scramble);
    int           idx;
    int           k;
    bit           seen;
    logic [127:0] exp;
    idx = int'(a[DL-1:0]);
    exp = wr ? 128'd0 : model[idx];
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    seen = 1'b0;
    k = 0;
    while (!seen && k < LAT + 6) begin
      @(negedge clk);
      k++;
      if (mem_ready) begin
        seen = 1'b1;
      end else begin
        check("wait_rdata", mem_rdata, 128'd0);
        if (scramble) begin
          mem_addr  = 28'($urandom);
          mem_wdata = rnd128();
        end
      end
    end
    check("ready", 128'(seen), 128'd1);
    check("latency", 128'(k), 128'(LAT));
    check("rdata", mem_rdata, exp);
    if (wr) model[idx] = d;
    if (rd && wr) err_m = 1'b1;
    if (wr) wr_m = sat_inc(wr_m);
    else rd_m = sat_inc(rd_m);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("turn_ready", 128'(mem_ready), 128'd0);
    check("turn_rdata", mem_rdata, 128'd0);
    check("err", 128'(mem_err), 128'(err_m));
    check_stats();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [27:0]  a;
    logic [127:0] d;
    int           k;
    int           r;
    bit           rd;
    bit           wr;

    err_m = 1'b0;
    rd_m  = 0;
    wr_m  = 0;
    proc_reset = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(mem_ready), 128'd0);
    check("rst_rdata", mem_rdata, 128'd0);
    check("rst_err", 128'(mem_err), 128'd0);
    check_stats();
    proc_reset = 1'b0;
    @(negedge clk);

    // give every line a known value; upper address bits are random
    for (int i = 0; i < N; i++) begin
      a = 28'($urandom);
      a[DL-1:0] = i[DL-1:0];
      txn(1'b0, 1'b1, a, rnd128(), 1'b0);
    end

    d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    txn(1'b0, 1'b1, 28'h0000012, d, 1'b0);
    txn(1'b1, 1'b0, 28'h0000012, '0, 1'b0);
    txn(1'b1, 1'b0, 28'h0000112, '0, 1'b1);
    txn(1'b1, 1'b0, 28'h0000013, '0, 1'b0);

    txn(1'b1, 1'b1, 28'h0000005, {128{1'b1}}, 1'b0);
    txn(1'b1, 1'b0, 28'h0000005, '0, 1'b0);
    txn(1'b1, 1'b0, 28'h0000012, '0, 1'b0);

    // reset two edges into a write must abort it
    txn(1'b0, 1'b1, 28'h0000007, '0, 1'b0);
    mem_write = 1'b1;
    mem_addr  = 28'h0000007;
    mem_wdata = rnd128();
    repeat (2) begin
      @(negedge clk);
      check("pre_abort_ready", 128'(mem_ready), 128'd0);
    end
    proc_reset = 1'b1;
    mem_write  = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
    err_m = 1'b0;
    rd_m  = 0;
    wr_m  = 0;
    check("abort_err", 128'(mem_err), 128'd0);
    check_stats();
    repeat (LAT + 2) begin
      @(negedge clk);
      check("abort_ready", 128'(mem_ready), 128'd0);
    end
    txn(1'b1, 1'b0, 28'h0000007, '0, 1'b0);

    // request held through DONE is accepted again after TURN
    d = rnd128();
    mem_write = 1'b1;
    mem_addr  = 28'h0000020;
    mem_wdata = d;
    wait_ready(k);
    check("b2b_first", 128'(k), 128'(LAT));
    wait_ready(k);
    check("b2b_second", 128'(k), 128'(LAT + 2));
    mem_write = 1'b0;
    model[8'h20] = d;
    wr_m = sat_inc(sat_inc(wr_m));
    @(negedge clk);
    check("b2b_turn", 128'(mem_ready), 128'd0);
    check_stats();
    @(negedge clk);
    txn(1'b1, 1'b0, 28'h0000020, '0, 1'b0);

    // randomized mix on a small index pool to force read-after-write hits
    repeat (120) begin
      r  = $urandom_range(0, 19);
      rd = (r < 9) || (r >= 18);
      wr = (r >= 9);
      a  = 28'($urandom);
      a[DL-1:0] = 8'($urandom_range(0, 15));
      txn(rd, wr, a, rnd128(), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
